// File: rtl/slow_stage_sequencer.sv
// rtl/slow_stage_sequencer.sv - clock-enable sequencer for the sync/decode/multiply pipeline
module slow_stage_sequencer #(
    parameter int CNT_W  = 4,
    parameter int SCNT_W = 8
) (
    input  logic              i_fast_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic [CNT_W-1:0]  i_div_ratio,
    output logic              o_sample_en,
    output logic              o_decode_en,
    output logic              o_mult_en,
    output logic              o_out_valid,
    output logic              o_busy,
    output logic [SCNT_W-1:0] o_result_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Period register is one bit wider than the ratio so P = 2^CNT_W fits.
    localparam logic [CNT_W:0]   PERIOD_RST = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]   PERIOD_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] RATIO_MIN  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [SCNT_W-1:0] RES_ONE   = SCNT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_div_cnt;
    logic [CNT_W:0]    r_period;
    logic [1:0]        r_v;
    logic              r_sample_en;
    logic              r_decode_en;
    logic              r_mult_en;
    logic              r_out_valid;
    logic              r_busy;
    logic [SCNT_W-1:0] r_result_cnt;

    logic [CNT_W-1:0]  w_ratio_clamped;
    logic [CNT_W:0]    w_period_new;
    logic [CNT_W:0]    w_period_m1;
    logic              w_active;
    logic              w_in_run;
    logic              w_tick;
    logic              w_drained;

    // A ratio of zero would give a one-cycle slot; it is clamped to one.
    assign w_ratio_clamped = (i_div_ratio == '0) ? RATIO_MIN : i_div_ratio;
    assign w_period_new    = {1'b0, w_ratio_clamped} + PERIOD_ONE;
    assign w_period_m1     = r_period - PERIOD_ONE;

    assign w_active = (r_state != ST_IDLE);
    assign w_in_run = (r_state == ST_RUN);
    assign w_tick   = w_active && ({1'b0, r_div_cnt} == w_period_m1);

    // Pipeline is empty once no stage holds data and no strobe or result pulse is still out.
    assign w_drained = (r_v == 2'b00) && !r_decode_en && !r_mult_en && !r_out_valid;

    // Next-state decode for IDLE / RUN / DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_run) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end else if (w_drained) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; busy mirrors "not IDLE" without a combinational output path.
    always_ff @(posedge i_fast_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Slot divider: held at zero in IDLE, free-running across RUN and DRAIN so re-entry keeps phase.
    always_ff @(posedge i_fast_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_period  <= PERIOD_RST;
        end else if (r_state == ST_IDLE) begin
            r_div_cnt <= '0;
            if (i_run) begin
                r_period <= w_period_new;
            end
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_ONE;
        end
    end

    // Stage strobes and stage-valid tracking, advanced only on slot ticks.
    always_ff @(posedge i_fast_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v         <= 2'b00;
            r_sample_en <= 1'b0;
            r_decode_en <= 1'b0;
            r_mult_en   <= 1'b0;
        end else if (w_tick) begin
            r_sample_en <= w_in_run;
            r_decode_en <= r_v[0];
            r_mult_en   <= r_v[1];
            r_v         <= {r_v[0], w_in_run};
        end else begin
            r_sample_en <= 1'b0;
            r_decode_en <= 1'b0;
            r_mult_en   <= 1'b0;
        end
    end

    // Result pulse trails the multiply load by one cycle; count every result, wrapping.
    always_ff @(posedge i_fast_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid  <= 1'b0;
            r_result_cnt <= '0;
        end else begin
            r_out_valid <= r_mult_en;
            if (r_out_valid) begin
                r_result_cnt <= r_result_cnt + RES_ONE;
            end
        end
    end

    assign o_sample_en  = r_sample_en;
    assign o_decode_en  = r_decode_en;
    assign o_mult_en    = r_mult_en;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = r_busy;
    assign o_result_cnt = r_result_cnt;

endmodule

// File: doc/slow_stage_sequencer.md
# slow_stage_sequencer

Single-clock sequencer that replaces the derived slow clock in the sync/decode/multiply datapath with clock-enable strobes. It divides `fast_clk` by a programmable ratio and issues one-cycle load strobes for the sync register, decode register and multiply register in pipeline order. It tracks which stages hold valid data, drains the pipeline cleanly when stopped, and counts completed results.

## Interface
- `CNT_W`, 4: width of divide-ratio input and divider counter.
- `SCNT_W`, 8: width of the completed-result counter.
- `fast_clk  in  1  sole clock; all state updates on rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `run  in  1  level request to sample and process data; sampled every edge`
- `div_ratio  in  CNT_W  slot period minus one; latched on IDLE->RUN; 0 treated as 1`
- `sample_en  out  1  one-cycle strobe: load synch register from shift register`
- `decode_en  out  1  one-cycle strobe: load decode register from comb stage 1`
- `mult_en  out  1  one-cycle strobe: load multiply register from comb stage 2`
- `out_valid  out  1  one-cycle pulse: multiply register holds a new valid result`
- `busy  out  1  high whenever state is not IDLE`
- `result_cnt  out  SCNT_W  number of out_valid pulses since reset, wraps`

## Operation
- Reset (async, `rst_n`=0): state IDLE, `div_cnt`=0, `v[1:0]`=0, latched period = 2, all strobes/`out_valid`/`busy`=0, `result_cnt`=0.
- Period P = max(div_ratio,1)+1, range 2..2^CNT_W; latched into internal register on IDLE->RUN only. Changes while busy are ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `div_cnt` held at 0. `run`=1 -> RUN (latch P, `div_cnt`<=0).
  - RUN: `run`=0 -> DRAIN; divider keeps counting.
  - DRAIN: `run`=1 -> RUN (no divider restart, P unchanged). Else -> IDLE on edge where `v`==0 and `decode_en`, `mult_en`, `out_valid` all 0.
- Divider: in RUN/DRAIN, `div_cnt` increments each edge; tick edge = edge where `div_cnt`==P-1, which sets `div_cnt`<=0.
- On tick edge: `sample_en`<=(state==RUN); `decode_en`<=v[0]; `mult_en`<=v[1]; v[0]<=(state==RUN); v[1]<=v[0].
- On non-tick edges: `sample_en`, `decode_en`, `mult_en` <= 0.
- `out_valid` <= `mult_en` every edge; `result_cnt` increments on each edge where `out_valid`=1, wraps 2^SCNT_W-1 -> 0.
- `busy` is registered: 1 in the cycle after entering RUN, 0 the cycle after returning to IDLE.
- Strobes never overlap for the same data item; at most one of each strobe per P cycles.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- `run` sampled high at edge 0: first tick at edge P; `sample_en` high cycle after edge P, `decode_en` after edge 2P, `mult_en` after edge 3P, `out_valid` after edge 3P+1.
- Steady RUN: one result every P cycles; latency from `sample_en` to `out_valid` = 2P+1 cycles.
- `run` dropped: the data item sampled at the last RUN tick still completes; no `sample_en` issued in DRAIN.
- `run` toggled in the same cycle as a tick: the state before the edge decides `sample_en`.
- Reset mid-operation: all strobes drop immediately (async); in-flight items are discarded and never produce `out_valid`.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN with P=4 -> all outputs 0 immediately, `result_cnt`=0, state IDLE after release.
- Steady run: div_ratio=3, `run`=1 at edge 0 -> `sample_en` after edges 4, 8, 12…; `decode_en` after edges 8, 12…; `mult_en` after edges 12, 16…; `out_valid` after edges 13, 17….
- Single item drain: div_ratio=1, `run` high for 2 cycles only -> exactly one `sample_en`, `decode_en`, `mult_en` and `out_valid`; `busy` falls after the final pulse; `result_cnt`=1.
- Clamp and mid-run change: div_ratio=0 -> P=2; change div_ratio to 7 while busy -> period stays 2 until the next IDLE->RUN.
- Re-entry from DRAIN: drop `run` for 1 cycle then raise it -> no divider restart, no lost or duplicated strobes, tick spacing stays P.
- Counter wrap: run 257 results with SCNT_W=8 -> `result_cnt`=1.
